sdram_req_arbiter: RTL and testbench

- Shares one SDRAM controller command port between two Wishbone-side requesters.
  - Requester 0 is the CPU data path.
  - Requester 1 is the instruction/prefetch path that fetches user code, e.g. matmul, from SDRAM-backed user memory.
- Schedules periodic auto-refresh commands with priority over requests.
- One outstanding transaction at a time; round-robin fairness between requesters.
- Sits between the user-project Wishbone decode and the SDRAM command controller.

---
 rtl/sdram_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Arbitrates two requesters onto one SDRAM controller command port, one transaction
// in flight at a time, with round-robin fairness and a periodic auto-refresh that has priority.
module sdram_req_arbiter #(
   parameter int unsigned ADDR_W     = 23,
   parameter int unsigned REF_PERIOD = 750,
   parameter int unsigned REF_CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [31:0]       r0_wdata,
   input  logic [3:0]        r0_wstrb,
   output logic              r0_rvalid,
   output logic [31:0]       r0_rdata,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [31:0]       r1_wdata,
   input  logic [3:0]        r1_wstrb,
   output logic              r1_rvalid,
   output logic [31:0]       r1_rdata,
   output logic              mc_valid,
   input  logic              mc_ready,
   output logic              mc_refresh,
   output logic              mc_we,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [31:0]       mc_wdata,
   output logic [3:0]        mc_wstrb,
   input  logic              mc_done,
   input  logic [31:0]       mc_rdata,
   output logic              busy,
   output logic              ref_overrun
);

   localparam logic [REF_CNT_W-1:0] REF_RELOAD = REF_CNT_W'(REF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_REF_ISSUE,
      S_REF_WAIT
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_grant;
   logic                  w_done_wait;
   logic                  w_ref_expire;
   logic                  w_ref_clear;

   logic                  r_last_grant;
   logic                  r_owner;
   logic                  r_we;
   logic [ADDR_W-1:0]     r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic [REF_CNT_W-1:0]  r_ref_cnt;
   logic                  r_ref_pending;
   logic                  r_ref_overrun;
   logic                  r_r0_rvalid;
   logic                  r_r1_rvalid;
   logic [31:0]           r_r0_rdata;
   logic [31:0]           r_r1_rdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and grant decode; refresh wins over any pending request in IDLE
   always_comb begin
      w_next   = r_state;
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_ref_pending) begin
               w_next = S_REF_ISSUE;
            end else if (r0_valid && (!r1_valid || r_last_grant)) begin
               w_grant0 = 1'b1;
               w_next   = S_ISSUE;
            end else if (r1_valid) begin
               w_grant1 = 1'b1;
               w_next   = S_ISSUE;
            end
         end
         S_ISSUE:     if (mc_ready) w_next = S_WAIT;
         S_WAIT:      if (mc_done)  w_next = S_IDLE;
         S_REF_ISSUE: if (mc_ready) w_next = S_REF_WAIT;
         S_REF_WAIT:  if (mc_done)  w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   assign w_grant      = w_grant0 | w_grant1;
   assign w_done_wait  = (r_state == S_WAIT) && mc_done;
   assign w_ref_expire = (r_ref_cnt == '0);
   assign w_ref_clear  = (r_state == S_REF_WAIT) && mc_done;

   // Command latch and owner; held stable for the whole ISSUE phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
      end else if (w_grant) begin
         r_last_grant <= w_grant1;
         r_owner      <= w_grant1;
         r_we         <= w_grant1 ? r1_we    : r0_we;
         r_addr       <= w_grant1 ? r1_addr  : r0_addr;
         r_wdata      <= w_grant1 ? r1_wdata : r0_wdata;
         r_wstrb      <= w_grant1 ? r1_wstrb : r0_wstrb;
      end
   end

   // Free-running refresh timer; a new expiry takes precedence over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref_cnt     <= REF_RELOAD;
         r_ref_pending <= 1'b0;
         r_ref_overrun <= 1'b0;
      end else begin
         if (w_ref_expire) r_ref_cnt <= REF_RELOAD;
         else              r_ref_cnt <= r_ref_cnt - REF_CNT_W'(1);

         if (w_ref_expire)     r_ref_pending <= 1'b1;
         else if (w_ref_clear) r_ref_pending <= 1'b0;

         if (w_ref_expire && r_ref_pending && !w_ref_clear) r_ref_overrun <= 1'b1;
      end
   end

   // Completion routing to the owner; writes return zero data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r0_rvalid <= 1'b0;
         r_r1_rvalid <= 1'b0;
         r_r0_rdata  <= '0;
         r_r1_rdata  <= '0;
      end else begin
         r_r0_rvalid <= w_done_wait && !r_owner;
         r_r1_rvalid <= w_done_wait &&  r_owner;
         r_r0_rdata  <= (w_done_wait && !r_owner && !r_we) ? mc_rdata : '0;
         r_r1_rdata  <= (w_done_wait &&  r_owner && !r_we) ? mc_rdata : '0;
      end
   end

   assign r0_ready    = w_grant0;
   assign r1_ready    = w_grant1;
   assign r0_rvalid   = r_r0_rvalid;
   assign r1_rvalid   = r_r1_rvalid;
   assign r0_rdata    = r_r0_rdata;
   assign r1_rdata    = r_r1_rdata;
   assign mc_valid    = (r_state == S_ISSUE) || (r_state == S_REF_ISSUE);
   assign mc_refresh  = (r_state == S_REF_ISSUE);
   assign mc_we       = r_we;
   assign mc_addr     = r_addr;
   assign mc_wdata    = r_wdata;
   assign mc_wstrb    = r_wstrb;
   assign busy        = (r_state != S_IDLE);
   assign ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: behavioural SDRAM controller, refresh/grant
// reference model, and per-requester queues of expected completions.
module tb_sdram_req_arbiter;

   localparam int unsigned ADDR_W     = 23;
   localparam int unsigned REF_PERIOD = 20;
   localparam int unsigned REF_CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              r0_valid, r0_ready, r0_we, r0_rvalid;
   logic [ADDR_W-1:0] r0_addr;
   logic [31:0]       r0_wdata, r0_rdata;
   logic [3:0]        r0_wstrb;
   logic              r1_valid, r1_ready, r1_we, r1_rvalid;
   logic [ADDR_W-1:0] r1_addr;
   logic [31:0]       r1_wdata, r1_rdata;
   logic [3:0]        r1_wstrb;
   logic              mc_valid, mc_ready, mc_refresh, mc_we, mc_done;
   logic [ADDR_W-1:0] mc_addr;
   logic [31:0]       mc_wdata, mc_rdata;
   logic [3:0]        mc_wstrb;
   logic              busy, ref_overrun;

   sdram_req_arbiter #(
      .ADDR_W(ADDR_W), .REF_PERIOD(REF_PERIOD), .REF_CNT_W(REF_CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_refresh(mc_refresh), .mc_we(mc_we),
      .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_wstrb(mc_wstrb), .mc_done(mc_done),
      .mc_rdata(mc_rdata), .busy(busy), .ref_overrun(ref_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [31:0] rq0[$];
   logic [31:0] rq1[$];
   int          grant_log[$];

   function automatic logic [31:0] rd_fn(input logic [ADDR_W-1:0] a);
      if (a == 23'h000100) return 32'h0000_003E;
      return {9'h0, a} ^ 32'hC0DE_0000;
   endfunction

   // Reference model of the refresh timer, driven only by the controller handshake
   int m_cnt;
   bit m_pend, m_ovr;
   int n_expiry = 0;
   bit done_is_ref;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= REF_PERIOD - 1;
         m_pend <= 1'b0;
         m_ovr  <= 1'b0;
      end else if (m_cnt == 0) begin
         m_cnt    <= REF_PERIOD - 1;
         m_pend   <= 1'b1;
         n_expiry <= n_expiry + 1;
         if (m_pend && !(mc_done && done_is_ref)) m_ovr <= 1'b1;
      end else begin
         m_cnt <= m_cnt - 1;
         if (mc_done && done_is_ref) m_pend <= 1'b0;
      end
   end

   // Behavioural SDRAM controller: configurable accept and completion delays
   int   rdy_dly = 0;
   int   done_dly = 1;
   int   wait_cnt, busy_cnt;
   int   n_ref_cmds = 0;
   bit   in_flight, cur_ref;
   logic [ADDR_W-1:0] cur_addr;
   logic [60:0]       snap;
   cmd_t              e;

   initial begin
      mc_ready = 1'b0; mc_done = 1'b0; mc_rdata = '0;
      in_flight = 1'b0; wait_cnt = 0; busy_cnt = 0; done_is_ref = 1'b0; cur_ref = 1'b0;
      forever begin
         @(posedge clk); #1;
         mc_done = 1'b0; done_is_ref = 1'b0; mc_rdata = 32'h1234_5678;
         if (!rst_n) begin
            mc_ready = 1'b0; in_flight = 1'b0; wait_cnt = 0;
         end else if (mc_ready) begin
            mc_ready = 1'b0; in_flight = 1'b1; busy_cnt = done_dly;
         end else if (in_flight) begin
            if (busy_cnt == 0) begin
               mc_done     = 1'b1;
               done_is_ref = cur_ref;
               mc_rdata    = cur_ref ? 32'hFFFF_FFFF : rd_fn(cur_addr);
               in_flight   = 1'b0;
            end else busy_cnt--;
         end else if (mc_valid) begin
            if (wait_cnt == 0) snap = {mc_refresh, mc_we, mc_addr, mc_wdata, mc_wstrb};
            else check("mc_stable", {mc_refresh, mc_we, mc_addr, mc_wdata, mc_wstrb}, snap);
            if (wait_cnt >= rdy_dly) begin
               mc_ready = 1'b1; wait_cnt = 0; cur_ref = mc_refresh; cur_addr = mc_addr;
               if (mc_refresh) begin
                  n_ref_cmds++;
                  check("ref_legit", m_pend, 1);
               end else if (cmd_q.size() == 0) begin
                  check("cmd_unexp", 1, 0);
               end else begin
                  e = cmd_q.pop_front();
                  check("mc_we", mc_we, e.we);
                  check("mc_addr", mc_addr, e.addr);
                  check("mc_wdata", mc_wdata, e.wdata);
                  check("mc_wstrb", mc_wstrb, e.wstrb);
               end
            end else wait_cnt++;
         end
      end
   end

   // Monitor: grant model, scoreboard push on accept, pop/compare on completion
   bit m_last = 1'b1;
   bit e0, e1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (!busy && !m_pend) begin
            e0 = r0_valid && (!r1_valid || m_last);
            e1 = r1_valid && !e0;
            check("grant", {r0_ready, r1_ready}, {e0, e1});
         end else begin
            check("no_ready", {r0_ready, r1_ready}, 2'b00);
         end
         if (r0_ready) begin
            m_last = 1'b0;
            grant_log.push_back(0);
            cmd_q.push_back('{r0_we, r0_addr, r0_wdata, r0_wstrb});
            rq0.push_back(r0_we ? 32'h0 : rd_fn(r0_addr));
         end
         if (r1_ready) begin
            m_last = 1'b1;
            grant_log.push_back(1);
            cmd_q.push_back('{r1_we, r1_addr, r1_wdata, r1_wstrb});
            rq1.push_back(r1_we ? 32'h0 : rd_fn(r1_addr));
         end
         if (r0_rvalid) begin
            check("r1_quiet", {r1_rvalid, r1_rdata}, 33'h0);
            check("busy_idle", busy, 0);
            if (rq0.size() == 0) check("r0_unexp", 1, 0);
            else check("r0_rdata", r0_rdata, rq0.pop_front());
         end
         if (r1_rvalid) begin
            check("r0_quiet", {r0_rvalid, r0_rdata}, 33'h0);
            check("busy_idle", busy, 0);
            if (rq1.size() == 0) check("r1_unexp", 1, 0);
            else check("r1_rdata", r1_rdata, rq1.pop_front());
         end
         check("ref_overrun", ref_overrun, m_ovr);
      end
   end

   // Present one request and hold it until accepted; caller is at posedge+1
   task automatic req(input int id, input bit we, input logic [ADDR_W-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      int t;
      bit got;
      t = 0; got = 1'b0;
      if (id == 0) begin r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; r0_wstrb = s; end
      else         begin r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; r1_wstrb = s; end
      while (!got && t < 500) begin
         @(negedge clk);
         got = (id == 0) ? r0_ready : r1_ready;
         t++;
      end
      if (!got) check("req_timeout", 0, 1);
      @(posedge clk); #1;
      if (id == 0) r0_valid = 1'b0;
      else         r1_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((rq0.size() != 0 || rq1.size() != 0 || cmd_q.size() != 0) && t < 1000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 1000) check("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, {r0_ready, r1_ready, r0_rvalid, r1_rvalid, mc_valid, mc_refresh,
                             mc_we, busy, ref_overrun, mc_wstrb}, 64'h0);
      check({tag, "_rdata"}, {r0_rdata, r1_rdata}, 64'h0);
      check({tag, "_mc"}, {mc_addr, mc_wdata}, 64'h0);
   endtask

   int exp0, ref0, d_exp, d_ref, t;

   initial begin
      rst_n = 1'b0;
      r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
      r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Single read with a two-cycle accept delay
      rdy_dly = 2; done_dly = 1;
      req(0, 1'b0, 23'h000100, 32'h0, 4'hF);
      drain();
      rdy_dly = 0;

      // Six contended writes/reads must alternate owners
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < 3; i++)
               req(0, (i != 1), 23'h001000 + 23'(i), 32'hA000_0000 + 32'(i), 4'hF);
         end
         begin
            for (int i = 0; i < 3; i++)
               req(1, (i != 1), 23'h002000 + 23'(i), 32'hB000_0000 + 32'(i), 4'h3);
         end
      join
      drain();
      check("n_grants", grant_log.size(), 6);
      for (int i = 1; i < grant_log.size(); i++)
         check("alternate", grant_log[i], 1 - grant_log[i-1]);

      // Long contention: refresh must keep pace with expiries
      exp0 = n_expiry; ref0 = n_ref_cmds;
      fork
         begin
            for (int i = 0; i < 12; i++)
               req(0, i[0], 23'h010000 + 23'(i), 32'h1111_0000 + 32'(i), 4'(i));
         end
         begin
            for (int i = 0; i < 12; i++)
               req(1, !i[0], 23'h020000 + 23'(i), 32'h2222_0000 + 32'(i), 4'(15 - i));
         end
      join
      drain();
      d_exp = n_expiry - exp0; d_ref = n_ref_cmds - ref0;
      check("ref_rate", ((d_exp - d_ref) <= 1) && ((d_ref - d_exp) <= 1), 1);
      check("ref_seen", d_ref >= 2, 1);
      check("no_overrun", ref_overrun, 0);

      // Backpressure: controller holds mc_ready low for 10 cycles
      rdy_dly = 10;
      req(1, 1'b1, 23'h003333, 32'hDEAD_BEEF, 4'h5);
      drain();
      rdy_dly = 0;

      // Overrun: completion withheld 45 cycles spans two expiries
      done_dly = 45;
      req(0, 1'b0, 23'h004444, 32'h0, 4'hF);
      drain();
      done_dly = 1;
      repeat (30) @(posedge clk);
      #1;
      check("overrun_sticky", ref_overrun, 1);

      // Reset during WAIT: the aborted request must never complete
      done_dly = 20;
      req(1, 1'b0, 23'h005555, 32'h0, 4'hF);
      t = 0;
      while (!(in_flight && !cur_ref) && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) check("wait_timeout", 0, 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      cmd_q.delete(); rq0.delete(); rq1.delete(); grant_log.delete();
      m_last = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      done_dly = 1;

      fork
         req(0, 1'b1, 23'h006000, 32'hCAFE_0000, 4'hF);
         req(1, 1'b1, 23'h007000, 32'hBEEF_0000, 4'hF);
      join
      drain();
      check("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
      repeat (5) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
